// File: rtl/saph_float_serialiser_if.sv
// Vector-in / element-out stream bundle for the float serialiser.
// Combinational bundle only, no latency of its own.
// The producer side honours in_ready; the consumer side stalls through out_ready.
interface saph_float_serialiser_if #(
  parameter int lanes = 2,
  parameter int fw    = 32
);
  localparam int LW = (lanes > 1) ? $clog2(lanes) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [lanes-1:0][fw-1:0]  in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [fw-1:0]             out_data;
  logic [LW-1:0]             out_lane;
  logic                      out_last;

  // Serialiser side: takes vectors in and drives elements out.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last
  );

  // Environment side: offers vectors and consumes elements.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/saph_float_serialiser.sv
// Buffers multi-lane float vectors in a small FIFO and emits them one lane per cycle.
// Latency: a push into an empty FIFO appears on the output on the next cycle.
// Backpressure: in_ready drops when full (overflow is sticky); out_ready stalls the lane walk.
module saph_float_serialiser #(
  parameter int lanes = 2,
  parameter int depth = 4,
  parameter int fw    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  saph_float_serialiser_if.slave       bus,
  output logic [$clog2(depth+1)-1:0]   level,
  output logic                         overflow
);
  localparam int AW = $clog2(depth);
  localparam int LW = (lanes > 1) ? $clog2(lanes) : 1;
  localparam int CW = $clog2(depth + 1);

  // Element values are opaque bit patterns; nothing here interprets them.
  logic [lanes-1:0][fw-1:0] mem_q [depth];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          ovf_q, ovf_d;

  logic in_rdy, out_vld, push, xfer, last_lane, pop;

  // Handshake flags come from registered state only, so no in->out or out_ready->in_ready path.
  always_comb begin
    in_rdy    = !rst && (level_q != CW'(depth));
    out_vld   = !rst && (level_q != '0);
    push      = bus.in_valid && in_rdy;
    xfer      = out_vld && bus.out_ready;
    last_lane = (lane_q == LW'(lanes - 1));
    pop       = xfer && last_lane;
  end

  // Next-state for pointers, lane counter, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    lane_d   = lane_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (xfer) lane_d = last_lane ? '0 : lane_q + LW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + CW'(1);
      2'b01:   level_d = level_q - CW'(1);
      default: level_d = level_q;
    endcase
    // A refused push is dropped; only the flag records it.
    if (bus.in_valid && !in_rdy) ovf_d = 1'b1;
  end

  // Control state register; reset also discards a partially sent head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      lane_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      lane_q   <= lane_d;
      ovf_q    <= ovf_d;
    end
  end

  // Vector storage; push already excludes reset and full cycles.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  // Present the current lane of the head vector.
  always_comb begin
    bus.in_ready  = in_rdy;
    bus.out_valid = out_vld;
    bus.out_data  = mem_q[rd_ptr_q][lane_q];
    bus.out_lane  = lane_q;
    bus.out_last  = last_lane;
    level         = level_q;
    overflow      = ovf_q;
  end
endmodule

// File: tb/tb_saph_float_serialiser.sv
// Randomised scoreboard bench for the float serialiser.
// Driver runs just after posedge, monitor samples on negedge.
// Expected elements are queued when a push is issued and popped on observed transfers.
module tb_saph_float_serialiser;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int FW    = 32;

  typedef logic [LANES-1:0][FW-1:0] vec_t;
  typedef struct {
    logic [FW-1:0] d;
    int            lane;
    bit            last;
  } elem_t;

  logic clk;
  logic rst;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic overflow;

  saph_float_serialiser_if #(.lanes(LANES), .fw(FW)) bus ();

  saph_float_serialiser #(.lanes(LANES), .depth(DEPTH), .fw(FW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .level    (level),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: list of pending elements in order, vector count, sticky flag.
  elem_t exp_q[$];
  int    mlevel;
  bit    movf;
  bit    drv_acc;
  bit    started;
  int    n_chk;
  int    n_fail;

  function automatic logic [31:0] fconst(real r);
    logic [63:0] b;
    int e;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic vec_t mkvec(real a, real b);
    vec_t v;
    v[0] = fconst(a);
    v[1] = fconst(b);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // One clock of stimulus; predicts acceptance from model occupancy.
  task automatic step(input bit v, input vec_t d, input bit ordy, input bit r, output bit acc);
    elem_t e;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    rst           = r;
    acc           = v && !r && (mlevel != DEPTH);
    drv_acc       = acc;
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        e.d    = d[i];
        e.lane = i;
        e.last = (i == LANES - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, a);
  endtask

  // Hold in_valid until the model says the vector was taken.
  task automatic push_wait(input vec_t d, input bit rand_rdy);
    bit a;
    int guard;
    a = 1'b0;
    guard = 0;
    while (!a && guard < 200) begin
      step(1'b1, d, rand_rdy ? 1'($urandom % 2) : 1'b1, 1'b0, a);
      guard++;
    end
    if (!a) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: vector not accepted within 200 cycles");
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mlevel != 0 || exp_q.size() != 0) && guard < 100) begin
      idle(1'b1, 1);
      guard++;
    end
    n_chk++;
    if (mlevel != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d elements left", exp_q.size());
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model past this edge.
  initial begin
    elem_t e;
    bit    exp_vld;
    bit    popv;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_vld = !rst && (mlevel != 0);
        popv    = 1'b0;
        chk("in_ready", 64'(bus.in_ready), 64'(!rst && (mlevel != DEPTH)));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
        chk("level", 64'(level), 64'(mlevel));
        chk("overflow", 64'(overflow), 64'(movf));
        if (exp_vld && exp_q.size() > 0) begin
          e = exp_q[0];
          chk("out_data", 64'(bus.out_data), 64'(e.d));
          chk("out_lane", 64'(bus.out_lane), 64'(e.lane));
          chk("out_last", 64'(bus.out_last), 64'(e.last));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            popv = e.last;
          end
        end
        if (rst) begin
          mlevel = 0;
          movf   = 1'b0;
          exp_q.delete();
        end else begin
          mlevel = mlevel + int'(drv_acc) - int'(popv);
          if (bus.in_valid && !drv_acc) movf = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit a;
    n_chk = 0;
    n_fail = 0;
    mlevel = 0;
    movf = 1'b0;
    drv_acc = 1'b0;
    started = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;

    // Reset, then one vector with the consumer ready.
    step(1'b0, '0, 1'b1, 1'b1, a);
    step(1'b0, '0, 1'b1, 1'b0, a);
    step(1'b1, mkvec(1.010, 3.141), 1'b1, 1'b0, a);
    idle(1'b1, 3);

    // Back-pressure: three vectors stall behind out_ready=0.
    for (int k = 0; k < 3; k++) step(1'b1, mkvec(10.5 + k, 20.25 + k), 1'b0, 1'b0, a);
    idle(1'b0, 4);
    drain();

    // Fill past capacity: fifth vector is dropped and the flag sticks.
    for (int k = 0; k < 5; k++) step(1'b1, mkvec(100.0 + k, 200.0 + k), 1'b0, 1'b0, a);
    idle(1'b0, 2);
    // At full with a pop on the last lane and a push offered, then keep pushing.
    step(1'b1, mkvec(300.0, 301.0), 1'b1, 1'b0, a);
    step(1'b1, mkvec(302.0, 303.0), 1'b1, 1'b0, a);
    for (int k = 0; k < 4; k++) step(1'b1, mkvec(310.0 + k, 320.0 + k), 1'b1, 1'b0, a);
    drain();
    idle(1'b1, 2);
    step(1'b0, '0, 1'b1, 1'b1, a);
    idle(1'b1, 2);

    // Pointer wrap under random consumer stalls.
    for (int k = 0; k < 10; k++) push_wait(mkvec(k + 0.125, k + 0.001), 1'b1);
    drain();

    // Reset part-way through draining a two-vector backlog.
    step(1'b1, mkvec(7.5, 8.5), 1'b0, 1'b0, a);
    step(1'b1, mkvec(9.5, 11.5), 1'b0, 1'b0, a);
    step(1'b0, '0, 1'b1, 1'b0, a);
    step(1'b0, '0, 1'b0, 1'b1, a);
    idle(1'b0, 2);
    step(1'b1, mkvec(42.0, 43.0), 1'b0, 1'b0, a);
    idle(1'b0, 2);
    drain();

    // Random burst mix with random stalls.
    for (int k = 0; k < 30; k++) begin
      step(1'($urandom % 2), mkvec(1000.0 + k, 2000.0 + k), 1'($urandom % 2), 1'b0, a);
    end
    drain();
    idle(1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/saph_float_serialiser.md
Name: saph_float_serialiser

Overview:
- Downstream stage for saph_float_incrementer.
- Captures each multi-lane `float` result vector into a small vector FIFO.
- Emits the buffered vectors one lane per cycle on a valid/ready stream, for example toward a debug/AXI writer.
- Decouples the incrementer's bursty vector output from a narrow, back-pressured consumer.

Parameters:
- lanes, 2, number of `float` elements per input vector (>=1).
- depth, 4, vector FIFO capacity in entries (power of two, >=2).

Ports:
- clk  input  1  GPU clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a vector to push this cycle.
- in_ready  output  1  FIFO can accept a vector.
- in_data  input  float x lanes  result vector (cur[] from incrementer).
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  consumer accepts the element.
- out_data  output  float  current element of the head vector.
- out_lane  output  max(1,$clog2(lanes))  index of out_data within its vector.
- out_last  output  1  out_data is the final lane of its vector.
- level  output  $clog2(depth+1)  number of vectors stored, including a partially drained head.
- overflow  output  1  sticky: a push was attempted while full.

Behaviour:
- Data type `float` from saph_defines.svh; treated as opaque bits, never arithmetic.
- Reset (rst high at posedge):
  - write/read pointers=0, level=0, lane counter=0, overflow=0.
  - While rst is high: in_ready=0, out_valid=0.
  - Reset mid-drain discards all stored vectors, including a partially sent head.
- Push fires when in_valid && in_ready.
  - Vector written to the write-pointer slot; pointer wraps modulo depth.
- in_ready = !rst && level != depth.
  - Depends only on registered state; it does NOT look at out_ready.
  - A pop in the same cycle does not free a slot until the next cycle.
- out_valid = level != 0, registered-state only.
  - Latency: a vector pushed at cycle N into an empty FIFO gives out_valid=1 at cycle N+1, with out_lane=0.
- out_data = head[lane]; out_lane = lane; out_last = (lane == lanes-1).
- Element transfer fires when out_valid && out_ready:
  - lane < lanes-1: lane++.
  - lane == lanes-1: lane=0, read pointer++ (wraps), vector popped.
- out_valid, out_data, out_lane, out_last must stay stable while out_valid && !out_ready.
- Level update:
  - Push only: level+1.
  - Pop only: level-1.
  - Push and pop in the same cycle: level unchanged, and both pointers advance.
- overflow is set when in_valid && !in_ready && !rst, and is cleared only by rst.
  - The dropped vector is discarded; stored data is unaffected.
- When out_valid=0, out_data/out_lane/out_last are don't-care (no X propagation required).
- lanes==1: out_lane is constant 0, out_last is constant 1, and each transfer pops.
- No combinational path from in_* to out_* or from out_ready to in_ready.

Test Plan:
- Reset then single vector: push {fconst(1.010), fconst(3.141)} at cycle 3 with out_ready=1.
  - out_valid rises at cycle 4: lane0=1.010 with out_last=0, then cycle 5: lane1=3.141 with out_last=1.
  - level goes 1,1,0.
- Back-pressure: push 3 vectors while out_ready=0.
  - level=3, out_data held at lane0 of vector0 for all stalled cycles.
  - Release out_ready: the 6 elements come out in push order, lanes 0,1,0,1,0,1.
- Full/overflow: push 5 vectors with out_ready=0 (depth=4).
  - in_ready=0 after the 4th push; the 5th is dropped and overflow=1 stays set.
  - Drain gives exactly the first 4 vectors.
  - overflow clears only after rst.
- Simultaneous push/pop at full: level=4, out_ready=1 on the last lane, in_valid=1.
  - in_ready=0, so no push and overflow=1.
  - Next cycle: level=3, in_ready=1; a push then keeps level at 3 while draining.
- Pointer wrap: stream 10 vectors {k+0.125, k+0.001} (k=0..9) with random out_ready at 50%.
  - The output sequence matches a reference queue exactly.
- Reset mid-drain: rst asserted after lane0 of a 2-vector backlog.
  - Next cycle: out_valid=0, level=0, lane=0.
  - A new push then emits from lane0.
